// File: rtl/ifu_fetch_if.sv
// AXI4-Lite read channel between the fetch unit (master) and instruction memory (slave).
interface ifu_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding AXI4-Lite read per request, flushable.
// Optional performance counters are enabled with the IFU_PERF_EN macro.
module ifu_fetch #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] FAULT_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_pc_i,
    input  logic              flush_i,
    ifu_fetch_if.master       axi,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_inst_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic              out_fault_o
`ifdef IFU_PERF_EN
   ,output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              fault_q, fault_d;
    logic              drop_q, drop_d;

    // State and captured-fetch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            fault_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic; a flush during AR/R is remembered because arvalid cannot be withdrawn.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (req_valid_i && !flush_i) begin
                    pc_d = req_pc_i;
                    if (req_pc_i[1:0] != 2'b00) begin
                        inst_d  = FAULT_INST;
                        fault_d = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_AR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AR: begin
                drop_d = drop_q | flush_i;
                if (axi.arready) begin
                    state_d = S_R;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                if (axi.rvalid) begin
                    fault_d = (axi.rresp != 2'b00);
                    inst_d  = (axi.rresp != 2'b00) ? FAULT_INST : axi.rdata;
                    if (drop_q || flush_i) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_OUT;
                    end
                end else begin
                    drop_d  = drop_q | flush_i;
                    state_d = S_R;
                end
            end
            S_OUT: begin
                if (flush_i || out_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                drop_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // req_ready must drop immediately while reset is held, not one edge later.
    assign req_ready_o = (state_q == S_IDLE) && !rst;
    assign axi.arvalid = (state_q == S_AR);
    assign axi.araddr  = pc_q;
    assign axi.rready  = (state_q == S_R);
    assign out_valid_o = (state_q == S_OUT);
    assign out_inst_o  = inst_q;
    assign out_pc_o    = pc_q;
    assign out_fault_o = fault_q;

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    // Delivered-instruction and memory-wait counters, free-running with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if ((state_q == S_OUT) && out_ready_i) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end else begin
                perf_fetch_q <= perf_fetch_q;
            end
            if ((state_q == S_AR) || (state_q == S_R)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios, then randomized traffic
// against a transaction-level reference model and a behavioural AXI-Lite slave.
module tb_ifu_fetch;
    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, flush, out_valid, out_ready, out_fault;
    logic [31:0] req_pc, out_inst, out_pc;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ifu_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi_if ();

    ifu_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FAULT_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_pc_i(req_pc),
        .flush_i(flush), .axi(axi_if),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_inst_o(out_inst),
        .out_pc_o(out_pc), .out_fault_o(out_fault)
`ifdef IFU_PERF_EN
       ,.perf_fetch_cnt_o(perf_fetch_cnt), .perf_stall_cnt_o(perf_stall_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Instruction memory contents and response codes, as functions of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0297;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        if (a == 32'h8000_0010) return 2'd2;
        if (a[6:2] == 5'h1F) return {1'b1, a[7]};
        return 2'd0;
    endfunction

    // Reference model: the one pending fetch and the read it still owes the bus.
    bit          p_act, p_fault, read_exp;
    logic [31:0] p_pc, p_inst, read_pc;
    // Slave state.
    bit          s_pend, rand_slave;
    logic [31:0] s_addr;
    int          s_wait, ar_hold, max_rwait;
    // Per-cycle event flags and statistics.
    bit          ev_acc, ev_ar, ev_r, ev_out;
    int          n_rhs, fetch_m, stall_m;

    task automatic model_clear();
        p_act = 1'b0; read_exp = 1'b0; s_pend = 1'b0; s_wait = 0; ar_hold = 0;
        fetch_m = 0; stall_m = 0;
    endtask

    // Called just after a falling edge with the bench inputs set; models the next rising edge.
    task automatic cycle();
        bit mis;
        if (s_pend && s_wait == 0) begin
            axi_if.rvalid = 1'b1;
            axi_if.rdata  = mem_word(s_addr);
            axi_if.rresp  = resp_of(s_addr);
        end else begin
            axi_if.rvalid = 1'b0;
            axi_if.rdata  = $urandom;
            axi_if.rresp  = 2'($urandom_range(0, 3));
        end
        if (axi_if.arvalid && ar_hold > 0) begin
            axi_if.arready = 1'b0;
            ar_hold--;
        end else if (rand_slave) begin
            axi_if.arready = 1'($urandom_range(0, 1));
        end else begin
            axi_if.arready = 1'b1;
        end
        #1;
        ev_acc = 1'b0; ev_ar = 1'b0; ev_r = 1'b0; ev_out = 1'b0;

        if (p_act) check_eq("one_outstanding", req_ready, 1'b0);
        if (axi_if.arvalid || axi_if.rready) stall_m++;
        if (axi_if.arvalid) begin
            check_eq("ar_expected", read_exp, 1'b1);
            check_eq("araddr", axi_if.araddr, read_pc);
            if (axi_if.arready) begin
                ev_ar = 1'b1; read_exp = 1'b0; s_pend = 1'b1; s_addr = axi_if.araddr;
                s_wait = rand_slave ? $urandom_range(0, max_rwait) : 0;
            end
        end
        if (axi_if.rvalid && axi_if.rready) begin
            ev_r = 1'b1; n_rhs++; s_pend = 1'b0;
        end else if (s_pend && s_wait > 0 && !ev_ar) begin
            s_wait--;
        end
        if (out_valid && out_ready) fetch_m++;
        if (out_valid && out_ready && !flush) begin
            ev_out = 1'b1;
            check_eq("out_expected", p_act, 1'b1);
            check_eq("out_inst", out_inst, p_inst);
            check_eq("out_pc", out_pc, p_pc);
            check_eq("out_fault", out_fault, p_fault);
            p_act = 1'b0;
        end
        if (flush) p_act = 1'b0;
        if (req_valid && req_ready && !flush) begin
            ev_acc  = 1'b1;
            mis     = (req_pc[1:0] != 2'b00);
            p_act   = 1'b1;
            p_pc    = req_pc;
            p_fault = mis || (resp_of(req_pc) != 2'd0);
            p_inst  = p_fault ? NOP : mem_word(req_pc);
            read_exp = !mis;
            read_pc  = req_pc;
        end
        @(negedge clk);
    endtask

    task automatic wait_out(input string tag, input int budget);
        for (int i = 0; i < budget && !out_valid; i++) cycle();
        check_eq(tag, out_valid, 1'b1);
    endtask

    task automatic issue(input logic [31:0] pc);
        req_valid = 1'b1; req_pc = pc;
        cycle();
        check_eq("req_accepted", ev_acc, 1'b1);
        req_valid = 1'b0;
    endtask

    initial begin
        int          rhs0, wait_cnt;
        logic [31:0] hold_inst;
        req_valid = 1'b0; req_pc = '0; flush = 1'b0; out_ready = 1'b1;
        axi_if.arready = 1'b0; axi_if.rvalid = 1'b0; axi_if.rdata = '0; axi_if.rresp = 2'd0;
        rand_slave = 1'b0; max_rwait = 0; n_rhs = 0;
        model_clear();
        repeat (2) @(negedge clk);

        // Reset values.
        check_eq("rst_req_ready", req_ready, 1'b0);
        check_eq("rst_arvalid", axi_if.arvalid, 1'b0);
        check_eq("rst_rready", axi_if.rready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_inst", out_inst, 32'd0);
        check_eq("rst_out_pc", out_pc, 32'd0);
        check_eq("rst_out_fault", out_fault, 1'b0);
        rst = 1'b0;
        #1 check_eq("post_rst_ready", req_ready, 1'b1);

        // Zero-wait fetch: AR, R, OUT on consecutive cycles.
        issue(32'h8000_0000);
        check_eq("t1_ar_c1", axi_if.arvalid, 1'b1);
        cycle();
        check_eq("t1_r_c2", axi_if.rready, 1'b1);
        cycle();
        check_eq("t1_out_c3", out_valid, 1'b1);
        check_eq("t1_inst", out_inst, 32'h0000_0297);
        check_eq("t1_pc", out_pc, 32'h8000_0000);
        check_eq("t1_fault", out_fault, 1'b0);
        cycle();
        check_eq("t1_bubble_ready", req_ready, 1'b1);

        // arready held low for 4 cycles.
        ar_hold = 4;
        issue(32'h8000_0100);
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_arvalid_held", axi_if.arvalid, 1'b1);
            check_eq("t2_araddr_held", axi_if.araddr, 32'h8000_0100);
            cycle();
        end
        check_eq("t2_arvalid_at_ready", axi_if.arvalid, 1'b1);
        cycle();
        check_eq("t2_ar_handshake", ev_ar, 1'b1);
        check_eq("t2_no_out_yet", out_valid, 1'b0);
        cycle();
        check_eq("t2_out_after_2", out_valid, 1'b1);
        cycle();

        // Misaligned PC faults without bus traffic.
        issue(32'h8000_0002);
        check_eq("t3_out_valid", out_valid, 1'b1);
        check_eq("t3_inst", out_inst, NOP);
        check_eq("t3_fault", out_fault, 1'b1);
        check_eq("t3_no_arvalid", axi_if.arvalid, 1'b0);
        cycle();

        // Error response.
        issue(32'h8000_0010);
        wait_out("t4_out_timeout", 10);
        check_eq("t4_inst", out_inst, NOP);
        check_eq("t4_fault", out_fault, 1'b1);
        check_eq("t4_pc", out_pc, 32'h8000_0010);
        cycle();

        // Flush while the address phase is pending.
        ar_hold = 3;
        issue(32'h8000_0020);
        check_eq("t5_in_ar", axi_if.arvalid, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        rhs0 = n_rhs;
        for (int i = 0; i < 20 && n_rhs == rhs0; i++) begin
            check_eq("t5_no_out_valid", out_valid, 1'b0);
            cycle();
        end
        check_eq("t5_read_completed", n_rhs - rhs0, 1);
        check_eq("t5_out_after_drop", out_valid, 1'b0);
        check_eq("t5_ready_after_drop", req_ready, 1'b1);

        // Output held under back-pressure, then reset mid-hold.
        out_ready = 1'b0;
        issue(32'h8000_0040);
        wait_out("t6_out_timeout", 10);
        hold_inst = mem_word(32'h8000_0040);
        for (int i = 0; i < 5; i++) begin
            check_eq("t6_hold_valid", out_valid, 1'b1);
            check_eq("t6_hold_inst", out_inst, hold_inst);
            check_eq("t6_hold_pc", out_pc, 32'h8000_0040);
            cycle();
        end
        rst = 1'b1;
        #1;
        check_eq("t6_rst_out_valid", out_valid, 1'b0);
        check_eq("t6_rst_req_ready", req_ready, 1'b0);
        model_clear();
        axi_if.rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1 check_eq("t6_ready_after_rst", req_ready, 1'b1);

        // Randomized traffic: random PCs, flushes, back-pressure and slave latency.
        rand_slave = 1'b1; max_rwait = 3; wait_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!req_valid && ($urandom_range(0, 2) == 0)) begin
                req_valid = 1'b1;
                req_pc    = $urandom;
                if ($urandom_range(0, 7) != 0) req_pc[1:0] = 2'b00;
                wait_cnt  = 0;
            end
            flush     = ($urandom_range(0, 11) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (ev_acc) begin
                req_valid = 1'b0;
            end else if (req_valid) begin
                wait_cnt++;
                if (wait_cnt > 60) begin
                    check_eq("req_starved", ev_acc, 1'b1);
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 30; i++) cycle();
        check_eq("drain_idle", req_ready, 1'b1);
`ifdef IFU_PERF_EN
        check_eq("perf_fetch", perf_fetch_cnt, 32'(fetch_m));
        check_eq("perf_stall", perf_stall_cnt, 32'(stall_m));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage sitting between the PC register and the decode pipeline register. It accepts a fetch request carrying a PC and issues one AXI4-Lite read on the instruction port. It returns the instruction word, its PC and a fault flag to decode over a valid/ready handshake. At most one fetch is outstanding. A flush input discards stale fetches after redirects (branch, ecall, mret).

Parameters:
ADDR_W, 32, PC / araddr width
DATA_W, 32, instruction / rdata width (fixed 32 for RV32)
FAULT_INST, 32'h0000_0013, instruction word emitted with a fault (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  PC stage presents a fetch request
req_ready  out  1  fetch unit can accept a request
req_pc  in  ADDR_W  PC to fetch
flush  in  1  discard in-flight or held fetch
araddr  out  ADDR_W  AXI-Lite read address
arvalid  out  1  read address valid
arready  in  1  slave accepts address
rdata  in  DATA_W  read data
rresp  in  2  read response (0 = OKAY)
rvalid  in  1  read data valid
rready  out  1  master accepts data
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts instruction
out_inst  out  DATA_W  fetched instruction
out_pc  out  ADDR_W  PC of out_inst
out_fault  out  1  access fault (misaligned PC or rresp!=0)

Behaviour:
- States: IDLE, AR, R, OUT. Async reset: state=IDLE, pc_q=0, inst_q=0, fault_q=0, drop_q=0.
- Output values while rst high: req_ready=0, arvalid=0, rready=0, out_valid=0, out_inst=0, out_pc=0, out_fault=0.
- Reset mid-transaction abandons the AXI read. The slave shares rst.
- IDLE: req_ready=1. On req_valid & ~flush:
  - Capture pc_q=req_pc.
  - If req_pc[1:0]!=0: inst_q=FAULT_INST, fault_q=1, go to OUT. No AXI traffic.
  - Otherwise go to AR.
  - req_valid together with flush in IDLE is ignored.
- AR: arvalid=1, araddr=pc_q. Both are held stable until arready. On arvalid & arready go to R.
- R: rready=1. On rvalid:
  - inst_q=rdata, fault_q=(rresp!=0).
  - If rresp!=0, inst_q=FAULT_INST.
  - Go to OUT, or to IDLE if the drop condition holds (see flush rules).
- OUT: out_valid=1, out_inst=inst_q, out_pc=pc_q, out_fault=fault_q.
  - On out_ready go to IDLE.
  - On flush go to IDLE regardless of out_ready; the instruction is not delivered.
- Flush rules:
  - In AR or R, flush sets drop_q, because AXI forbids withdrawing arvalid. The read completes normally, its data is discarded, and the next state is IDLE instead of OUT. drop_q clears on entering IDLE.
  - The drop condition at rvalid is drop_q | flush.
- Latency: request accept to out_valid is ≥3 cycles with a zero-wait slave (IDLE→AR→R→OUT). Misaligned request to out_valid is 1 cycle.
- req_ready is deasserted in AR, R and OUT. The PC stage must hold req_valid/req_pc until accepted.
- out_* are registered; no combinational path from rdata to out_inst.
- araddr is driven from pc_q only.
- Back-to-back fetches have one IDLE bubble cycle.

Optional Feature:
IFU_PERF_EN:
- Defined: adds outputs perf_fetch_cnt (32b) and perf_stall_cnt (32b), both reset to 0.
  - perf_fetch_cnt increments on each out_valid & out_ready.
  - perf_stall_cnt increments each cycle in AR or R.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Zero-wait slave, req_pc=0x8000_0000, rdata=0x0000_0297, rresp=0, out_ready=1 -> AR at cycle 1, R at 2, out_valid at 3 with inst 0x0000_0297, pc 0x8000_0000, fault 0.
- Slave holds arready=0 for 4 cycles -> arvalid stays 1 and araddr stays constant across all 4 cycles; out_valid appears 2 cycles after the arready cycle.
- req_pc=0x8000_0002 -> no arvalid ever; next cycle out_valid=1, out_inst=0x0000_0013, out_fault=1.
- rresp=2 on rvalid for pc 0x8000_0010 -> out_fault=1, out_inst=0x0000_0013, out_pc=0x8000_0010.
- flush pulsed during AR -> read still completes (rready handshake happens), out_valid never asserts, state returns to IDLE, req_ready=1 next cycle.
- out_ready=0 for 5 cycles in OUT, then rst asserted mid-hold -> outputs stable while held; rst immediately forces out_valid=0, req_ready=0; after release req_ready=1.
